// File: rtl/display_arb_pkg.sv
// display_arb_pkg
// Shared definitions for the display arbiter slice.
//   arb_state_t      : arbiter FSM encoding (IDLE, OWN, GAP)
//   DEFAULT_W        : default display number width, matches seven_segment
//   dwell_cnt_width  : bits needed to hold a dwell count of 0 .. dwell-1
// GAP is only entered when DISPLAY_ARB_BLANK_EN is defined.
package display_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEFAULT_W = 16;

    // The counter saturates at dwell-1, so a one-bit counter covers DWELL of 1 or 2.
    function automatic int dwell_cnt_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first candidate found when
// scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
// Ports:
//   req   in   N_REQ   request vector
//   ptr   in   PTR_W   index where the scan starts (must be < N_REQ)
//   mask  in   N_REQ   requesters excluded from this pick
//   pick  out  N_REQ   one-hot winner, 0 when no candidate
//   valid out  1       1 when pick != 0
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    logic [N_REQ-1:0] cand;

    assign cand = req & ~mask;

    // Two ascending passes implement the wrap: first the indices at or above
    // ptr, then the ones below it. The first hit wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && cand[i] && (i >= int'(ptr))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && cand[i] && (i < int'(ptr))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter
// Round-robin sharing of the 4-digit seven_segment display between N_REQ
// value producers, with a minimum dwell time counted in en strobes.
// Ports:
//   clk        in   1         system clock
//   reset      in   1         synchronous, active-high reset
//   en         in   1         strobe; state only changes on edges with en=1
//   req        in   N_REQ     level-sensitive request per source
//   num_flat   in   N_REQ*W   source i value in [i*W +: W]
//   dots_flat  in   N_REQ*4   source i dots in [i*4 +: 4]
//   grant      out  N_REQ     one-hot current owner, 0 when none
//   active     out  1         1 when grant != 0
//   num        out  W         owner's value, 0 when no owner
//   dots       out  4         owner's dots, 0 when no owner
// Optional feature: DISPLAY_ARB_BLANK_EN inserts a one-strobe blank (GAP)
// on every owner switch.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DWELL = 8,
    parameter int W     = DEFAULT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] num_flat,
    input  logic [N_REQ*4-1:0] dots_flat,
    output logic [N_REQ-1:0]   grant,
    output logic               active,
    output logic [W-1:0]       num,
    output logic [3:0]         dots
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = dwell_cnt_width(DWELL);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] dwell_cnt;

    logic [PTR_W-1:0] owner_idx;
    logic [PTR_W-1:0] ptr_after_owner;
    logic             owner_req;
    logic [N_REQ-1:0] idle_pick;
    logic             idle_valid;
    logic [N_REQ-1:0] sw_pick;
    logic             sw_valid;
    logic             do_switch;

    // Index of the current owner, recovered from the one-hot grant register.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign owner_req       = |(req & grant);
    assign ptr_after_owner = (owner_idx == LAST_IDX) ? '0 : owner_idx + 1'b1;

    // Fresh pick from the stored pointer (used from IDLE and GAP).
    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick_idle (
        .req   (req),
        .ptr   (ptr),
        .mask  ('0),
        .pick  (idle_pick),
        .valid (idle_valid)
    );

    // Switch pick: scan from just after the owner and never re-pick the owner.
    // This is the same pointer the switch writes back into ptr.
    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick_switch (
        .req   (req),
        .ptr   (ptr_after_owner),
        .mask  (grant),
        .pick  (sw_pick),
        .valid (sw_valid)
    );

    // A switch happens on release with another requester waiting, or once the
    // dwell has run out while someone else is waiting. Release is checked
    // first, but both paths lead to the same switch so they share one term.
    assign do_switch = (state == OWN) && sw_valid && (!owner_req || (dwell_cnt == DWELL_MAX));

    // Arbiter FSM: owner register, round-robin pointer and dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            dwell_cnt <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (idle_valid) begin
                        grant     <= idle_pick;
                        dwell_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (do_switch) begin
                        ptr       <= ptr_after_owner;
                        dwell_cnt <= '0;
`ifdef DISPLAY_ARB_BLANK_EN
                        grant     <= '0;
                        state     <= GAP;
`else
                        grant     <= sw_pick;
`endif
                    end else if (!owner_req) begin
                        grant     <= '0;
                        dwell_cnt <= '0;
                        state     <= IDLE;
                    end else if (dwell_cnt != DWELL_MAX) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
`ifdef DISPLAY_ARB_BLANK_EN
                GAP: begin
                    dwell_cnt <= '0;
                    if (idle_valid) begin
                        grant <= idle_pick;
                        state <= OWN;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    grant     <= '0;
                    dwell_cnt <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Output mux follows the registered grant; no owner means a blank display.
    always_comb begin
        num  = '0;
        dots = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                num  = num_flat[i*W +: W];
                dots = dots_flat[i*4 +: 4];
            end
        end
    end

    assign active = |grant;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter
// Self-checking bench for display_arbiter with N_REQ=4, DWELL=8, W=16 and
// en asserted one clk in four. Build with DISPLAY_ARB_BLANK_EN defined to
// check the blanking variant.
module tb_display_arbiter;

    localparam int N_REQ = 4;
    localparam int DWELL = 8;
    localparam int W     = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*W-1:0]  num_flat;
    logic [N_REQ*4-1:0]  dots_flat;
    logic [N_REQ-1:0]    grant;
    logic                active;
    logic [W-1:0]        num;
    logic [3:0]          dots;

    always #5 clk = ~clk;

    display_arbiter #(
        .N_REQ (N_REQ),
        .DWELL (DWELL),
        .W     (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .num_flat  (num_flat),
        .dots_flat (dots_flat),
        .grant     (grant),
        .active    (active),
        .num       (num),
        .dots      (dots)
    );

    typedef struct {
        string      name;
        logic [3:0] grant;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[13];
    int   checks = 0;
    int   fails  = 0;

    // Reference model state (random phase only)
    int m_state;
    int m_owner;
    int m_ptr;
    int m_dwell;

    function automatic logic [15:0] src_num(input logic [3:0] g);
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) return num_flat[i*W +: W];
        end
        return 16'h0000;
    endfunction

    function automatic logic [3:0] src_dots(input logic [3:0] g);
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) return dots_flat[i*4 +: 4];
        end
        return 4'h0;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard: got output with no expectation, expected a queued entry");
        end else begin
            e = exp_q.pop_front();
            compare({e.name, ".grant"},  {28'd0, grant},   {28'd0, e.grant});
            compare({e.name, ".active"}, {31'd0, active},  {31'd0, |e.grant});
            compare({e.name, ".num"},    {16'd0, num},     {16'd0, src_num(e.grant)});
            compare({e.name, ".dots"},   {28'd0, dots},    {28'd0, src_dots(e.grant)});
        end
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] r, input logic [3:0] expg);
        @(negedge clk);
        req = r;
        en  = 1'b1;
        exp_q.push_back('{name, expg});
        @(posedge clk);
        #1;
        en = 1'b0;
        checkOutput();
        repeat (3) @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int mpick(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (start + k) % N_REQ;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_dwell = 0;
    endtask

    task automatic model_switch(input int p);
        m_ptr   = (m_owner + 1) % N_REQ;
        m_dwell = 0;
`ifdef DISPLAY_ARB_BLANK_EN
        m_state = 2;
        m_owner = -1;
`else
        m_owner = p;
`endif
    endtask

    task automatic model_step(input logic [3:0] r, output logic [3:0] g);
        int p;
        if (m_state == 0) begin
            p = mpick(r, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_dwell = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            p = mpick(r, (m_owner + 1) % N_REQ, m_owner);
            if (!r[m_owner]) begin
                if (p >= 0) model_switch(p);
                else begin
                    m_state = 0;
                    m_owner = -1;
                    m_dwell = 0;
                end
            end else if (m_dwell < DWELL - 1) begin
                m_dwell++;
            end else if (p >= 0) begin
                model_switch(p);
            end
        end else begin
            p = mpick(r, m_ptr, -1);
            m_dwell = 0;
            m_owner = p;
            m_state = (p >= 0) ? 1 : 0;
        end
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] r;
        logic [3:0] g;

        // Release/switch walk from reset, expected grants derived by hand
        tbl[0]  = '{4'b0001, 4'b0001};
        tbl[1]  = '{4'b1001, 4'b0001};
        tbl[2]  = '{4'b1001, 4'b0001};
        tbl[5]  = '{4'b0000, 4'b0000};
        tbl[6]  = '{4'b0110, 4'b0010};
        tbl[11] = '{4'b1111, 4'b1000};
        tbl[12] = '{4'b0000, 4'b0000};
`ifdef DISPLAY_ARB_BLANK_EN
        tbl[3]  = '{4'b1000, 4'b0000};
        tbl[4]  = '{4'b1000, 4'b1000};
        tbl[7]  = '{4'b0100, 4'b0000};
        tbl[8]  = '{4'b0101, 4'b0100};
        tbl[9]  = '{4'b0001, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000};
`else
        tbl[3]  = '{4'b1000, 4'b1000};
        tbl[4]  = '{4'b1000, 4'b1000};
        tbl[7]  = '{4'b0100, 4'b0100};
        tbl[8]  = '{4'b0101, 4'b0100};
        tbl[9]  = '{4'b0001, 4'b0001};
        tbl[10] = '{4'b0000, 4'b0000};
`endif

        num_flat  = {16'hD333, 16'hBEEF, 16'hB111, 16'hA000};
        dots_flat = {4'h3, 4'h5, 4'h9, 4'hC};
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back('{"reset", 4'b0000});
        checkOutput();
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("table%0d", i), tbl[i].req, tbl[i].exp_grant);
        end

        // Reset in the middle of a grant, then ptr must be back at 0
        applyStimulus("pre_reset", 4'b0100, 4'b0100);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back('{"reset_mid", 4'b0000});
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput();
        applyStimulus("ptr_after_reset", 4'b1111, 4'b0001);

        // Sole requester keeps the display
        doReset();
        for (int k = 0; k < 50; k++) begin
            applyStimulus("sole_hold", 4'b0100, 4'b0100);
        end
        compare("sole_num_beef", {16'd0, num}, 32'h0000BEEF);

`ifndef DISPLAY_ARB_BLANK_EN
        // Full contention rotates every DWELL strobes
        doReset();
        for (int k = 1; k <= 40; k++) begin
            applyStimulus("rotate", 4'b1111, 4'(1 << (((k - 1) / DWELL) % N_REQ)));
        end
`else
        // Blank strobe between owners
        doReset();
        for (int k = 1; k <= 10; k++) begin
            if (k <= DWELL)          applyStimulus("blank_own0", 4'b0011, 4'b0001);
            else if (k == DWELL + 1) applyStimulus("blank_gap",  4'b0011, 4'b0000);
            else                     applyStimulus("blank_own1", 4'b0011, 4'b0010);
        end
`endif

        // en held low: req toggles but nothing moves
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus("hold_setup", 4'b0011, 4'b0001);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            req = 4'($urandom_range(15));
            en  = 1'b0;
            @(posedge clk);
            #1;
            compare("en_low_grant", {28'd0, grant}, 32'h1);
            compare("en_low_num",   {16'd0, num},   32'h0000A000);
        end
`ifdef DISPLAY_ARB_BLANK_EN
        applyStimulus("resume", 4'b0010, 4'b0000);
`else
        applyStimulus("resume", 4'b0010, 4'b0010);
`endif
        applyStimulus("resume2", 4'b0010, 4'b0010);

        // Random phase against the reference model
        doReset();
        model_reset();
        r = 4'b0000;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
            model_step(r, g);
            applyStimulus("random", r, g);
        end

        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
